// File: rtl/esp_sid_pkg.sv
// Shared constants and types for the ESP-to-SID bridge.
// Used by esp_sid_spi_rx and esp_sid_top.
package esp_sid_pkg;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;
    localparam int NUM_REGS   = 32;

    typedef logic [ADDR_W-1:0] sid_addr_t;
    typedef logic [DATA_W-1:0] sid_data_t;
endpackage

// File: rtl/esp_sid_spi_rx.sv
// Write-only SPI mode-0 slave: synchronisers, sclk edge detect, 16-bit frame assembly
// and a one-clk write strobe carrying the register address and data byte.
module esp_sid_spi_rx
    import esp_sid_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      ss,
    input  logic      sclk,
    input  logic      mosi,
    output logic      ss_sync,
    output logic      write_en,
    output sid_addr_t addr,
    output sid_data_t data
);
    logic [SYNC_STAGES-1:0] ss_pipe;
    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   sclk_prev;
    logic [3:0]             bit_cnt;
    logic [FRAME_BITS-1:0]  shift;
    logic                   sclk_sync;
    logic                   mosi_sync;
    logic                   sclk_rise;
    logic                   unused_addr_hi;

    assign ss_sync   = ss_pipe[SYNC_STAGES-1];
    assign sclk_sync = sclk_pipe[SYNC_STAGES-1];
    assign mosi_sync = mosi_pipe[SYNC_STAGES-1];
    assign sclk_rise = sclk_sync & ~sclk_prev;

    // The shift register still holds the completed frame while write_en is high.
    assign addr = shift[ADDR_W+DATA_W-1:DATA_W];
    assign data = shift[DATA_W-1:0];
    assign unused_addr_hi = ^shift[FRAME_BITS-1:ADDR_W+DATA_W];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // ss resets to the deselected level so led_d2 stays off until a real select.
            ss_pipe   <= '1;
            sclk_pipe <= '0;
            mosi_pipe <= '0;
            sclk_prev <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
            write_en  <= 1'b0;
        end else begin
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], ss};
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync;
            write_en  <= 1'b0;
            if (ss_sync) begin
                bit_cnt <= '0;
                shift   <= '0;
            end else if (sclk_rise) begin
                shift    <= {shift[FRAME_BITS-2:0], mosi_sync};
                bit_cnt  <= bit_cnt + 4'd1;
                write_en <= (bit_cnt == 4'(FRAME_BITS - 1));
            end
        end
    end
endmodule

// File: rtl/esp_sid_top.sv
// ESP-to-SID bridge top: SPI receiver, 32x8 SID register file, sid_clk divider, LEDs.
// Optional macro ESP_SID_LED_STRETCH_EN turns led_d1 into a stretched write pulse.
module esp_sid_top
    import esp_sid_pkg::*;
#(
    parameter int CLK_DIV     = 16,
    parameter int STRETCH_W   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic led_d1,
    output logic led_d2,
    output logic sid_clk,
    input  logic ss,
    input  logic sclk,
    input  logic mosi
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic             ss_sync;
    logic             write_en;
    sid_addr_t        wr_addr;
    sid_data_t        wr_data;
    sid_data_t        regfile [NUM_REGS];
    logic [DIV_W-1:0] div_cnt;

    esp_sid_spi_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_spi_rx (
        .clk     (clk),
        .rst     (rst),
        .ss      (ss),
        .sclk    (sclk),
        .mosi    (mosi),
        .ss_sync (ss_sync),
        .write_en(write_en),
        .addr    (wr_addr),
        .data    (wr_data)
    );

    // NOTE: the register file is small and must read 0x00 after reset, so it is built
    // from resettable flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regfile[i] <= '0;
        end else if (write_en) begin
            regfile[wr_addr] <= wr_data;
        end
    end

    // Free-running divider; toggling at the half and full count gives a 50% duty cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sid_clk <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
            if (div_cnt == DIV_W'(CLK_DIV / 2 - 1) || div_cnt == DIV_W'(CLK_DIV - 1))
                sid_clk <= ~sid_clk;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) led_d2 <= 1'b0;
        else     led_d2 <= ~ss_sync;
    end

`ifdef ESP_SID_LED_STRETCH_EN
    logic [STRETCH_W-1:0] stretch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   stretch_cnt <= '0;
        else if (write_en)         stretch_cnt <= '1;
        else if (stretch_cnt != '0) stretch_cnt <= stretch_cnt - 1'b1;
    end

    assign led_d1 = (stretch_cnt != '0);
`else
    logic [STRETCH_W-1:0] unused_stretch;
    assign unused_stretch = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           led_d1 <= 1'b0;
        else if (write_en) led_d1 <= ~led_d1;
    end
`endif
endmodule

// File: tb/tb_esp_sid_top.sv
// Self-checking bench for esp_sid_top: SPI bursts driven asynchronously to clk and
// compared against a frame-level model of the register file.
module tb_esp_sid_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic led_d1;
    logic led_d2;
    logic sid_clk;

    esp_sid_top #(
        .CLK_DIV    (16),
        .STRETCH_W  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .led_d1 (led_d1),
        .led_d2 (led_d2),
        .sid_clk(sid_clk),
        .ss     (ss),
        .sclk   (sclk),
        .mosi   (mosi)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    logic [7:0]  model_regs [32];
    logic [12:0] exp_q [$];
    logic [12:0] got_q [$];
    bit          tx_bits [$];
    logic        led_d2_mid;
    int          led_toggles = 0;
    logic        led_prev = 1'b0;

    // Write monitor and LED edge counter, sampled away from the active edge.
    always @(negedge clk) begin
        if (dut.write_en === 1'b1) got_q.push_back({dut.wr_addr, dut.wr_data});
        if (led_d1 !== led_prev) led_toggles++;
        led_prev = led_d1;
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
    endtask

    // Every complete 16-bit group inside one select window is a write; the rest is dropped.
    task automatic model_burst();
        int nframes;
        nframes = tx_bits.size() / 16;
        for (int f = 0; f < nframes; f++) begin
            int word = 0;
            int a;
            int d;
            for (int b = 0; b < 16; b++) word = word * 2 + int'(tx_bits[16 * f + b]);
            a = (word / 256) % 32;
            d = word % 256;
            exp_q.push_back({5'(a), 8'(d)});
            model_regs[a] = 8'(d);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
    endtask

    // sclk period 50 ns; transitions sit 3 ns off the clk grid so they never race it.
    task automatic spi_burst();
        @(posedge clk);
        #3;
        ss = 1'b0;
        #40;
        for (int i = 0; i < tx_bits.size(); i++) begin
            mosi = tx_bits[i];
            #25 sclk = 1'b1;
            #25 sclk = 1'b0;
            if (i == tx_bits.size() / 2) led_d2_mid = led_d2;
        end
        #40;
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (10) @(posedge clk);
        model_burst();
        tx_bits.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        model_reset();
        checks++;
        if (sid_clk !== 1'b0) begin
            fails++;
            $display("FAIL reset_sid_clk: got %b expected 0", sid_clk);
        end
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checks++;
        if (led_d1 !== 1'b0 || led_d2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_leds: got d1=%b d2=%b expected 0 0", led_d1, led_d2);
        end
        checks++;
        if (got_q.size() !== 0) begin
            fails++;
            $display("FAIL reset_no_write: got %0d writes expected 0", got_q.size());
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.regfile[i] !== 8'h00) begin
                fails++;
                $display("FAIL reset_reg[%0d]: got %h expected 00", i, dut.regfile[i]);
            end
        end
    endtask

    task automatic test_sid_clk();
        int n;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (sid_clk !== 1'b1 && n < 40);
        checks++;
        if (n !== 8) begin
            fails++;
            $display("FAIL sid_clk_first_rise: got %0d clks expected 8", n);
        end
        for (int p = 0; p < 6; p++) begin
            logic lvl;
            lvl = sid_clk;
            n = 0;
            do begin
                @(posedge clk);
                #1 n++;
            end while (sid_clk === lvl && n < 40);
            checks++;
            if (n !== 8) begin
                fails++;
                $display("FAIL sid_clk_phase%0d: level %b lasted %0d clks expected 8", p, lvl, n);
            end
        end
    endtask

    task automatic test_alternating();
        int base;
        base = exp_q.size();
        for (int i = 0; i < 200; i++) tx_bits.push_back(bit'(i % 2));
        spi_burst();
        checks++;
        if (got_q.size() - base !== 12 || exp_q.size() - base !== 12) begin
            fails++;
            $display("FAIL alt_write_count: got %0d expected 12", got_q.size() - base);
        end
        for (int i = base; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== {5'h15, 8'h55}) begin
                fails++;
                $display("FAIL alt_write%0d: got %h expected %h", i - base,
                         (i < got_q.size()) ? got_q[i] : 13'h0, {5'h15, 8'h55});
            end
        end
        checks++;
        if (dut.regfile[21] !== 8'h55) begin
            fails++;
            $display("FAIL alt_reg21: got %h expected 55", dut.regfile[21]);
        end
        checks++;
        if (led_d2_mid !== 1'b1 || led_d2 !== 1'b0) begin
            fails++;
            $display("FAIL alt_led_d2: got mid=%b after=%b expected 1 0", led_d2_mid, led_d2);
        end
    endtask

    task automatic test_byte_toggle();
        int base;
        tx_bits.delete();
        push_byte(8'h1F);
        push_byte(8'hC3);
        spi_burst();
        base = exp_q.size();
        for (int i = 0; i < 25; i++) push_byte((i % 2 == 0) ? 8'hFF : 8'h00);
        spi_burst();
        checks++;
        if (got_q.size() - base !== 12) begin
            fails++;
            $display("FAIL toggle_write_count: got %0d expected 12", got_q.size() - base);
        end
        for (int i = base; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== {5'h1F, 8'h00}) begin
                fails++;
                $display("FAIL toggle_write%0d: got %h expected %h", i - base,
                         (i < got_q.size()) ? got_q[i] : 13'h0, {5'h1F, 8'h00});
            end
        end
        checks++;
        if (dut.regfile[31] !== 8'h00) begin
            fails++;
            $display("FAIL toggle_reg31: got %h expected 00", dut.regfile[31]);
        end
    endtask

    task automatic test_abort();
        int base;
        push_byte(8'h03);
        push_byte(8'h3C);
        spi_burst();
        base = got_q.size();
        push_byte(8'h03);
        for (int i = 0; i < 5; i++) tx_bits.push_back(1'b1);
        spi_burst();
        push_byte(8'h02);
        push_byte(8'hA7);
        spi_burst();
        checks++;
        if (got_q.size() - base !== 1) begin
            fails++;
            $display("FAIL abort_write_count: got %0d expected 1", got_q.size() - base);
        end
        checks++;
        if (dut.regfile[2] !== 8'hA7) begin
            fails++;
            $display("FAIL abort_reg2: got %h expected a7", dut.regfile[2]);
        end
        checks++;
        if (dut.regfile[3] !== 8'h3C) begin
            fails++;
            $display("FAIL abort_reg3: got %h expected 3c", dut.regfile[3]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int nbits;
            int base;
            base  = exp_q.size();
            nbits = 16 * $urandom_range(1, 4) + $urandom_range(0, 15);
            for (int i = 0; i < nbits; i++) tx_bits.push_back(bit'($urandom_range(0, 1)));
            spi_burst();
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                fails++;
                $display("FAIL rand%0d_write_count: got %0d expected %0d", r, got_q.size(), exp_q.size());
            end
            for (int i = base; i < exp_q.size(); i++) begin
                checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL rand%0d_write%0d: got %h expected %h", r, i - base,
                             (i < got_q.size()) ? got_q[i] : 13'h0, exp_q[i]);
                end
            end
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.regfile[i] !== model_regs[i]) begin
                fails++;
                $display("FAIL rand_reg[%0d]: got %h expected %h", i, dut.regfile[i], model_regs[i]);
            end
        end
    endtask

    task automatic test_led();
        int   t0;
        logic lvl0;
        @(negedge clk);
        t0   = led_toggles;
        lvl0 = led_d1;
        push_byte(8'h08);
        push_byte(8'h11);
        push_byte(8'h09);
        push_byte(8'h22);
        spi_burst();
        @(negedge clk);
`ifdef ESP_SID_LED_STRETCH_EN
        checks++;
        if (led_d1 !== 1'b1) begin
            fails++;
            $display("FAIL led_stretch_on: got %b expected 1", led_d1);
        end
        repeat (200) @(negedge clk);
        checks++;
        if (led_d1 !== 1'b1) begin
            fails++;
            $display("FAIL led_stretch_hold: got %b expected 1", led_d1);
        end
        repeat (100) @(negedge clk);
        checks++;
        if (led_d1 !== 1'b0) begin
            fails++;
            $display("FAIL led_stretch_off: got %b expected 0", led_d1);
        end
`else
        checks++;
        if (led_toggles - t0 !== 2) begin
            fails++;
            $display("FAIL led_toggle_count: got %0d expected 2", led_toggles - t0);
        end
        checks++;
        if (led_d1 !== lvl0) begin
            fails++;
            $display("FAIL led_toggle_level: got %b expected %b", led_d1, lvl0);
        end
`endif
        checks++;
        if (dut.regfile[8] !== model_regs[8] || dut.regfile[9] !== model_regs[9]) begin
            fails++;
            $display("FAIL led_regs: got %h %h expected %h %h", dut.regfile[8], dut.regfile[9],
                     model_regs[8], model_regs[9]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        base = got_q.size();
        @(posedge clk);
        #3 ss = 1'b0;
        #40;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'b1;
            #25 sclk = 1'b1;
            #25 sclk = 1'b0;
        end
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (led_d1 !== 1'b0 || led_d2 !== 1'b0 || sid_clk !== 1'b0) begin
            fails++;
            $display("FAIL midrst_outputs: got d1=%b d2=%b sid=%b expected 0 0 0", led_d1, led_d2, sid_clk);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.regfile[i] !== 8'h00) begin
                fails++;
                $display("FAIL midrst_reg[%0d]: got %h expected 00", i, dut.regfile[i]);
            end
        end
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (got_q.size() !== base) begin
            fails++;
            $display("FAIL midrst_no_write: got %0d writes expected 0", got_q.size() - base);
        end
        push_byte(8'h05);
        push_byte(8'h5A);
        spi_burst();
        checks++;
        if (dut.regfile[5] !== 8'h5A || got_q.size() - base !== 1) begin
            fails++;
            $display("FAIL midrst_recover: got reg5=%h writes=%0d expected 5a 1",
                     dut.regfile[5], got_q.size() - base);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sid_clk();
        test_alternating();
        test_byte_toggle();
        test_abort();
        test_random();
        test_led();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
